// File: rtl/pipelined_decode_ctrl.sv
// RV32I ID-stage decoder with the ID/EX control pipeline register.
// Handles load-use bubbles, downstream holds and flushes, and keeps saturating stall/illegal counters.
module pipelined_decode_ctrl #(
  parameter bit SUPPORT_JUMP  = 1'b1,
  parameter bit SUPPORT_UPPER = 1'b1,
  parameter bit HAZARD_EN     = 1'b1,
  parameter int STAT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       instr,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              if_id_stall,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_alusrc,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_jalr,
  output logic [2:0]        ex_aluop,
  output logic [4:0]        ex_rd,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7b5,
  output logic              ex_illegal,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [STAT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [2:0] aluop;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       illegal;
  } idex_t;

  idex_t             idex_q, idex_d, dec;
  logic              uses_rs1, uses_rs2, hazard;
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  // Immediate-only bits that no control depends on.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:25]};

  always_comb begin
    dec          = '0;
    uses_rs1     = 1'b0;
    uses_rs2     = 1'b0;
    dec.valid    = 1'b1;
    dec.rd       = instr[11:7];
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.funct3   = instr[14:12];
    dec.funct7b5 = instr[30];
    case (instr[6:0])
      OP_R: begin
        dec.regwrite = 1'b1;
        dec.aluop    = 3'b010;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
      end
      OP_I: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.aluop    = 3'b011;
        uses_rs1     = 1'b1;
      end
      OP_LOAD: begin
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.alusrc   = 1'b1;
        uses_rs1     = 1'b1;
      end
      OP_STORE: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
      end
      OP_BR: begin
        dec.branch = 1'b1;
        dec.aluop  = 3'b001;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
      end
      OP_JAL: begin
        if (SUPPORT_JUMP) begin
          dec.regwrite = 1'b1;
          dec.jump     = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_JALR: begin
        if (SUPPORT_JUMP) begin
          dec.regwrite = 1'b1;
          dec.jump     = 1'b1;
          dec.jalr     = 1'b1;
          dec.alusrc   = 1'b1;
          uses_rs1     = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_LUI: begin
        if (SUPPORT_UPPER) begin
          dec.regwrite = 1'b1;
          dec.alusrc   = 1'b1;
          dec.aluop    = 3'b100;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_AUIPC: begin
        if (SUPPORT_UPPER) begin
          dec.regwrite = 1'b1;
          dec.alusrc   = 1'b1;
          dec.aluop    = 3'b101;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.rd == 5'd0) dec.regwrite = 1'b0;
  end

  always_comb begin
    hazard = HAZARD_EN & id_valid & idex_q.valid & idex_q.memread & (idex_q.rd != 5'd0) &
             ((uses_rs1 & (idex_q.rd == instr[19:15])) | (uses_rs2 & (idex_q.rd == instr[24:20])));
    if_id_stall = ~flush & (ex_hold | hazard);
  end

  always_comb begin
    idex_d        = idex_q;
    stall_cnt_d   = stall_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (flush) begin
      idex_d = '0;
    end else if (ex_hold) begin
      idex_d = idex_q;
    end else if (hazard) begin
      idex_d = '0;
      if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end else begin
      idex_d = id_valid ? dec : '0;
      if (id_valid && dec.illegal && (illegal_cnt_q != CNT_MAX))
        illegal_cnt_d = illegal_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q        <= '0;
      stall_cnt_q   <= '0;
      illegal_cnt_q <= '0;
    end else begin
      idex_q        <= idex_d;
      stall_cnt_q   <= stall_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign ex_valid    = idex_q.valid;
  assign ex_regwrite = idex_q.regwrite;
  assign ex_memread  = idex_q.memread;
  assign ex_memwrite = idex_q.memwrite;
  assign ex_memtoreg = idex_q.memtoreg;
  assign ex_alusrc   = idex_q.alusrc;
  assign ex_branch   = idex_q.branch;
  assign ex_jump     = idex_q.jump;
  assign ex_jalr     = idex_q.jalr;
  assign ex_aluop    = idex_q.aluop;
  assign ex_rd       = idex_q.rd;
  assign ex_rs1      = idex_q.rs1;
  assign ex_rs2      = idex_q.rs2;
  assign ex_funct3   = idex_q.funct3;
  assign ex_funct7b5 = idex_q.funct7b5;
  assign ex_illegal  = idex_q.illegal;
  assign stall_cnt   = stall_cnt_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule
